inst_fifo: RTL and testbench
============================

Name: inst_fifo

Overview:
- Dual-port instruction queue between the fetch-side instruction splitter and dual-issue decode.
- Accepts up to two {pc, inst} pairs per cycle from fetch and presents up to two oldest entries to decode, first-word fall-through.
- Decouples fetch-bandwidth variation (one or two valid words per fetch) from issue width.
- Flushed on branch redirect or exception.

Parameters:
DEPTH, 16, number of entries; power of two, >= 4
AW, log2(DEPTH), pointer width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
flush  input  1  discard all entries (redirect/exception)
write_en1  input  1  push slot 1
write_en2  input  1  push slot 2; honoured only with write_en1
write_pc1  input  32  pc of slot 1
write_inst1  input  32  instruction of slot 1
write_pc2  input  32  pc of slot 2
write_inst2  input  32  instruction of slot 2
read_en1  input  1  pop oldest entry
read_en2  input  1  pop second-oldest entry; honoured only with read_en1
read_pc1  output  32  pc of oldest entry
read_inst1  output  32  instruction of oldest entry
read_pc2  output  32  pc of second-oldest entry
read_inst2  output  32  instruction of second-oldest entry
empty  output  1  count == 0
almost_empty  output  1  count <= 1 (slot 2 invalid)
full  output  1  count >= DEPTH-1 (cannot guarantee room for two)
count  output  AW+1  number of valid entries

Behaviour:
- State: DEPTH x 64-bit storage, head and tail pointers (AW bits, wrap modulo DEPTH), count (AW+1 bits).
- Reset: head = tail = count = 0; empty = 1, almost_empty = 1, full = 0; all read_* outputs = 0. Storage contents are don't-care.
- Read outputs are combinational from storage at head and head+1 (mod DEPTH).
  - read_pc1/read_inst1 = 0 when empty.
  - read_pc2/read_inst2 = 0 when almost_empty.
  - Zero-forcing is required, because decode treats inst 0 as nop.
- Pop count (based on start-of-cycle count):
  - npop = 0 if !read_en1 or count == 0.
  - npop = 1 if read_en1 && (!read_en2 || count == 1).
  - npop = 2 otherwise.
  - Reads past valid data are silently truncated.
- Push count:
  - npush = 0 if !write_en1 or full.
  - npush = 1 + write_en2 otherwise.
  - write_en2 without write_en1 is ignored.
  - A write while full is dropped entirely, even if a same-cycle read frees space. Upstream stalls on full.
- Push writes slot 1 at tail and slot 2 at tail+1 (mod DEPTH). Then tail += npush, head += npop, count += npush - npop, all in one clock.
- Simultaneous push and pop:
  - Legal at any count, including empty with a push.
  - A push into an empty queue is visible on read_* the next cycle, not the same cycle (no write-to-read bypass).
- Flush has the highest priority. Same-cycle pushes and pops are discarded. Next cycle: head = tail = count = 0, empty = 1.
- Flags are combinational from count; no registered lag.
- Asynchronous reset mid-operation clears state immediately, independent of clk.
- Latency: one cycle from accepted write to data visible at read port.

Test Plan:
- Reset, then write_en1=1, write_en2=1, pc 0xBFC00000/0xBFC00004, inst 0x24080001/0x24090002 -> next cycle: count=2, empty=0, almost_empty=0, read_pc1=0xBFC00000, read_inst2=0x24090002.
- Fill with single writes until count=15 -> full=1. A further dual write with read_en1=1 is dropped -> count=14 and the head advances by one.
- count=1, read_en1=1, read_en2=1 -> one pop; count=0, empty=1, all read_* = 0.
- Wrap-around: push/pop 2 per cycle for 20 cycles with incrementing pc from 0x1000 -> pcs pop in order 0x1000, 0x1004, ... across the pointer wrap; count stays constant.
- flush=1 with count=7 and simultaneous write_en1/read_en1 -> next cycle count=0, empty=1; the pushed pcs never appear on the outputs.
- Drive resetn low asynchronously mid-cycle with count=5 -> count=0 and read_* = 0 before the next clk edge; normal operation resumes after release.

Source files
------------

// File: rtl/inst_fifo_if.sv
// inst_fifo_if: fetch/decode side bundle of the dual-port instruction queue.
//   master: drives flush, write_* and read_en*, observes read_* and the flags
//   slave:  the queue itself
interface inst_fifo_if #(parameter int DEPTH = 16);
  localparam int AW = $clog2(DEPTH);
  logic flush;
  logic write_en1, write_en2;
  logic [31:0] write_pc1, write_inst1, write_pc2, write_inst2;
  logic read_en1, read_en2;
  logic [31:0] read_pc1, read_inst1, read_pc2, read_inst2;
  logic empty, almost_empty, full;
  logic [AW:0] count;
  modport master (
    output flush, write_en1, write_en2, write_pc1, write_inst1, write_pc2, write_inst2,
    output read_en1, read_en2,
    input read_pc1, read_inst1, read_pc2, read_inst2, empty, almost_empty, full, count
  );
  modport slave (
    input flush, write_en1, write_en2, write_pc1, write_inst1, write_pc2, write_inst2,
    input read_en1, read_en2,
    output read_pc1, read_inst1, read_pc2, read_inst2, empty, almost_empty, full, count
  );
endinterface

// File: rtl/inst_fifo.sv
// inst_fifo: dual-push/dual-pop first-word fall-through instruction queue.
//   clk    system clock, rising edge
//   resetn asynchronous active-low reset
//   bus    inst_fifo_if.slave: flush, two push slots, two pop slots, flags, count
module inst_fifo #(parameter int DEPTH = 16) (
  input logic clk,
  input logic resetn,
  inst_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [63:0] mem_q [DEPTH];
  logic [63:0] mem_d [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d, head_n1, tail_n1;
  logic [AW:0] count_q, count_d;
  logic [1:0] npush, npop;
  logic empty, almost_empty, full;
  assign empty = count_q == '0;
  assign almost_empty = count_q <= (AW+1)'(1);
  // full leaves headroom for a dual push, so a one-free-slot queue still stalls fetch
  assign full = count_q >= (AW+1)'(DEPTH-1);
  assign head_n1 = head_q + AW'(1);
  assign tail_n1 = tail_q + AW'(1);
  always_comb begin
    npop = (!bus.read_en1 || empty) ? 2'd0 : (!bus.read_en2 || count_q == (AW+1)'(1)) ? 2'd1 : 2'd2;
    npush = (!bus.write_en1 || full) ? 2'd0 : bus.write_en2 ? 2'd2 : 2'd1;
    mem_d = mem_q;
    if (!bus.flush && npush != 2'd0) mem_d[tail_q] = {bus.write_pc1, bus.write_inst1};
    if (!bus.flush && npush == 2'd2) mem_d[tail_n1] = {bus.write_pc2, bus.write_inst2};
    head_d = bus.flush ? '0 : head_q + AW'(npop);
    tail_d = bus.flush ? '0 : tail_q + AW'(npush);
    count_d = bus.flush ? '0 : count_q + (AW+1)'(npush) - (AW+1)'(npop);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  // decode treats inst 0 as a nop, so invalid slots must read as zero
  assign bus.read_pc1 = empty ? '0 : mem_q[head_q][63:32];
  assign bus.read_inst1 = empty ? '0 : mem_q[head_q][31:0];
  assign bus.read_pc2 = almost_empty ? '0 : mem_q[head_n1][63:32];
  assign bus.read_inst2 = almost_empty ? '0 : mem_q[head_n1][31:0];
  assign bus.empty = empty;
  assign bus.almost_empty = almost_empty;
  assign bus.full = full;
  assign bus.count = count_q;
endmodule

// File: tb/tb_inst_fifo.sv
// tb_inst_fifo: scoreboard bench for inst_fifo (directed vectors, queue-based pop checking).
`timescale 1ns/1ps
module tb_inst_fifo;
  logic clk = 1'b0;
  logic resetn;
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q [$];
  inst_fifo_if #(.DEPTH(16)) b ();
  inst_fifo #(.DEPTH(16)) dut (.clk(clk), .resetn(resetn), .bus(b));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", n, act, exp);
    end
  endtask
  task automatic pop_cmp(input string n, input logic [63:0] act);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s got %h exp none", n, act);
    end else begin
      logic [63:0] e;
      e = exp_q.pop_front();
      if (act !== e) begin
        errors++;
        $display("FAIL %s got %h exp %h", n, act, e);
      end
    end
  endtask
  always @(negedge clk) begin
    if (resetn && !b.flush && b.read_en1 && !b.empty) begin
      pop_cmp("pop1", {b.read_pc1, b.read_inst1});
      if (b.read_en2 && !b.almost_empty) pop_cmp("pop2", {b.read_pc2, b.read_inst2});
    end
  end
  task automatic idle();
    b.flush = 1'b0;
    b.write_en1 = 1'b0;
    b.write_en2 = 1'b0;
    b.write_pc1 = '0;
    b.write_inst1 = '0;
    b.write_pc2 = '0;
    b.write_inst2 = '0;
    b.read_en1 = 1'b0;
    b.read_en2 = 1'b0;
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask
  task automatic wr(input logic [31:0] p1, input logic [31:0] i1, input logic two,
                    input logic [31:0] p2, input logic [31:0] i2, input logic acc);
    b.write_en1 = 1'b1;
    b.write_pc1 = p1;
    b.write_inst1 = i1;
    b.write_en2 = two;
    b.write_pc2 = p2;
    b.write_inst2 = i2;
    if (acc) begin
      exp_q.push_back({p1, i1});
      if (two) exp_q.push_back({p2, i2});
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    idle();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 64'(b.count), 64'd0);
    chk("rst_empty", 64'(b.empty), 64'd1);
    chk("rst_aempty", 64'(b.almost_empty), 64'd1);
    chk("rst_full", 64'(b.full), 64'd0);
    chk("rst_rd1", {b.read_pc1, b.read_inst1}, 64'd0);
    chk("rst_rd2", {b.read_pc2, b.read_inst2}, 64'd0);
    resetn = 1'b1;
    cyc();
    wr(32'hBFC00000, 32'h24080001, 1'b1, 32'hBFC00004, 32'h24090002, 1'b1);
    cyc();
    chk("dual_count", 64'(b.count), 64'd2);
    chk("dual_empty", 64'(b.empty), 64'd0);
    chk("dual_aempty", 64'(b.almost_empty), 64'd0);
    chk("dual_pc1", 64'(b.read_pc1), 64'hBFC00000);
    chk("dual_inst2", 64'(b.read_inst2), 64'h24090002);
    for (int i = 0; i < 13; i++) begin
      wr(32'h100 + 32'(4 * i), 32'h1000 + 32'(i), 1'b0, '0, '0, 1'b1);
      cyc();
      if (i == 11) begin
        chk("c14_full", 64'(b.full), 64'd0);
        chk("c14_count", 64'(b.count), 64'd14);
      end
    end
    chk("c15_full", 64'(b.full), 64'd1);
    chk("c15_count", 64'(b.count), 64'd15);
    wr(32'hAAAA0000, 32'h1, 1'b1, 32'hAAAA0004, 32'h2, 1'b0);
    b.read_en1 = 1'b1;
    cyc();
    chk("drop_count", 64'(b.count), 64'd14);
    chk("drop_head", 64'(b.read_pc1), 64'hBFC00004);
    for (int i = 0; i < 6; i++) begin
      b.read_en1 = 1'b1;
      b.read_en2 = 1'b1;
      cyc();
    end
    b.read_en1 = 1'b1;
    cyc();
    chk("c1_count", 64'(b.count), 64'd1);
    chk("c1_aempty", 64'(b.almost_empty), 64'd1);
    chk("c1_pc1", 64'(b.read_pc1), 64'h130);
    chk("c1_rd2_zero", {b.read_pc2, b.read_inst2}, 64'd0);
    b.read_en1 = 1'b1;
    b.read_en2 = 1'b1;
    cyc();
    chk("trunc_count", 64'(b.count), 64'd0);
    chk("trunc_empty", 64'(b.empty), 64'd1);
    chk("trunc_rd1", {b.read_pc1, b.read_inst1}, 64'd0);
    chk("trunc_rd2", {b.read_pc2, b.read_inst2}, 64'd0);
    wr(32'h1000, 32'h0F001000, 1'b1, 32'h1004, 32'h0F001004, 1'b1);
    cyc();
    for (int k = 0; k < 20; k++) begin
      wr(32'h1008 + 32'(8 * k), 32'h0F001008 + 32'(8 * k), 1'b1,
         32'h100C + 32'(8 * k), 32'h0F00100C + 32'(8 * k), 1'b1);
      b.read_en1 = 1'b1;
      b.read_en2 = 1'b1;
      cyc();
      chk("wrap_count", 64'(b.count), 64'd2);
    end
    b.read_en1 = 1'b1;
    b.read_en2 = 1'b1;
    cyc();
    chk("wrap_empty", 64'(b.empty), 64'd1);
    for (int i = 0; i < 3; i++) begin
      wr(32'h2000 + 32'(8 * i), 32'h20 + 32'(i), 1'b1, 32'h2004 + 32'(8 * i), 32'h40 + 32'(i), 1'b1);
      cyc();
    end
    wr(32'h2018, 32'h60, 1'b0, '0, '0, 1'b1);
    cyc();
    chk("pre_flush_count", 64'(b.count), 64'd7);
    b.flush = 1'b1;
    wr(32'hDEAD0000, 32'hDEAD, 1'b0, '0, '0, 1'b0);
    b.read_en1 = 1'b1;
    exp_q.delete();
    cyc();
    chk("flush_count", 64'(b.count), 64'd0);
    chk("flush_empty", 64'(b.empty), 64'd1);
    chk("flush_rd1", {b.read_pc1, b.read_inst1}, 64'd0);
    wr(32'h3000, 32'h33, 1'b0, '0, '0, 1'b1);
    cyc();
    chk("post_flush_pc1", 64'(b.read_pc1), 64'h3000);
    chk("post_flush_count", 64'(b.count), 64'd1);
    b.read_en1 = 1'b1;
    cyc();
    chk("post_flush_empty", 64'(b.empty), 64'd1);
    wr(32'h5000, 32'h50, 1'b1, 32'h5004, 32'h51, 1'b1);
    cyc();
    wr(32'h5008, 32'h52, 1'b1, 32'h500C, 32'h53, 1'b1);
    cyc();
    wr(32'h5010, 32'h54, 1'b0, '0, '0, 1'b1);
    cyc();
    chk("pre_arst_count", 64'(b.count), 64'd5);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_count", 64'(b.count), 64'd0);
    chk("arst_empty", 64'(b.empty), 64'd1);
    chk("arst_rd1", {b.read_pc1, b.read_inst1}, 64'd0);
    chk("arst_rd2", {b.read_pc2, b.read_inst2}, 64'd0);
    exp_q.delete();
    #1;
    resetn = 1'b1;
    cyc();
    wr(32'h4000, 32'h40, 1'b1, 32'h4004, 32'h41, 1'b1);
    cyc();
    chk("resume_count", 64'(b.count), 64'd2);
    chk("resume_pc1", 64'(b.read_pc1), 64'h4000);
    chk("resume_pc2", 64'(b.read_pc2), 64'h4004);
    b.read_en1 = 1'b1;
    b.read_en2 = 1'b1;
    cyc();
    chk("resume_empty", 64'(b.empty), 64'd1);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
